tdm_demux_1x8: RTL and testbench

- Receive-side counterpart of the 8x1 mux path: accepts a time-division-multiplexed serial stream, one lane per valid beat.
- Steers each beat to lane 0..7 using an internal slot counter, which replaces the external select.
- Assembles a full 8-lane frame in a shadow register and publishes it atomically with a one-cycle strobe.
- Sits between a serialised link and the parallel consumer logic.

---
 rtl/tdm_demux_1x8_pkg.sv | 8 +
 rtl/tdm_demux_1x8_dec_3x8.sv | 8 +
 rtl/tdm_demux_1x8.sv | 54 +++++
 tb/tb_tdm_demux_1x8.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_1x8_pkg.sv
// tdm_demux_1x8_pkg: shared sizes and state encodings for the TDM demux
package tdm_demux_1x8_pkg;
  localparam int NUM_LANES = 8;
  localparam int SEL_W = 3;
  localparam int LANE_W = 1;
  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
endpackage

// File: rtl/tdm_demux_1x8_dec_3x8.sv
// dec_3x8: one-hot 3-to-8 decoder with enable
module dec_3x8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] y
);
  assign y = en ? 8'b1 << sel : 8'b0;
endmodule

// File: rtl/tdm_demux_1x8.sv
// tdm_demux_1x8: slot-counted 1-to-8 TDM demultiplexer with atomic frame publish
module tdm_demux_1x8
  import tdm_demux_1x8_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANE_W-1:0]           din,
  input  logic                        din_valid,
  input  logic                        frame_start,
  output logic [NUM_LANES*LANE_W-1:0] y,
  output logic                        frame_valid,
  output logic                        sync_err,
  output logic [SEL_W-1:0]            s,
  output logic                        locked
);
  logic [0:0] state;
  logic [NUM_LANES*LANE_W-1:0] shadow, shadow_nx;
  logic [NUM_LANES-1:0] we;
  logic [SEL_W-1:0] sel;
  logic run, realign, lost, wr, commit;
  always_comb begin
    run = state == ST_RUN;
    realign = din_valid && run && frame_start && s != '0;
    lost = din_valid && run && !frame_start && s == '0;
    wr = din_valid && (run ? !lost : frame_start);
    sel = realign ? '0 : s;
    commit = wr && !frame_start && s == SEL_W'(NUM_LANES - 1);
  end
  dec_3x8 u_dec (.sel(sel), .en(wr), .y(we));
  // a framing violation wipes the partial frame before the new lane 0 lands
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign shadow_nx[k*LANE_W +: LANE_W] = we[k] ? din :
      (realign || lost) ? '0 : shadow[k*LANE_W +: LANE_W];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HUNT;
      s <= '0;
      shadow <= '0;
      y <= '0;
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      frame_valid <= commit;
      sync_err <= realign || lost;
      shadow <= shadow_nx;
      if (wr) s <= sel + SEL_W'(1);
      if (wr) state <= ST_RUN;
      else if (lost) state <= ST_HUNT;
      if (commit) y <= shadow_nx;
    end
  end
  assign locked = state == ST_RUN;
endmodule

// File: tb/tb_tdm_demux_1x8.sv
// tb_tdm_demux_1x8: directed and random checks against a frame-queue reference model
module tb_tdm_demux_1x8;
  logic clk = 1'b0;
  logic rst, din, din_valid, frame_start;
  logic [7:0] y;
  logic frame_valid, sync_err, locked;
  logic [2:0] s;
  int checks = 0, errors = 0, cyc = 0;
  logic [3:0] bq[$];
  bit m_lanes[$];
  bit m_locked, m_fv, m_se;
  logic [7:0] m_y;

  tdm_demux_1x8 dut (.clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .y(y), .frame_valid(frame_valid),
    .sync_err(sync_err), .s(s), .locked(locked));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] got();
    return {y, frame_valid, sync_err, s, locked};
  endfunction

  function automatic logic [13:0] expv();
    return {m_y, m_fv, m_se, 3'(m_lanes.size()), m_locked};
  endfunction

  // beat = {rst, valid, frame_start, data}
  task automatic model(input logic [3:0] b);
    m_fv = 0;
    m_se = 0;
    if (b[3]) begin
      m_locked = 0; m_lanes.delete(); m_y = 8'h00;
    end else if (b[2]) begin
      if (!m_locked) begin
        if (b[1]) begin m_lanes.delete(); m_lanes.push_back(b[0]); m_locked = 1; end
      end else if (b[1]) begin
        m_se = m_lanes.size() != 0;
        m_lanes.delete(); m_lanes.push_back(b[0]);
      end else if (m_lanes.size() == 0) begin
        m_se = 1; m_locked = 0;
      end else begin
        m_lanes.push_back(b[0]);
        if (m_lanes.size() == 8) begin
          for (int k = 0; k < 8; k++) m_y[k] = m_lanes[k];
          m_fv = 1;
          m_lanes.delete();
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] b);
    {rst, din_valid, frame_start, din} = b;
    @(posedge clk);
    #1;
    model(b);
  endtask

  task automatic add_frame(input logic [7:0] d, input int gap_after = -1, input int gap_len = 0);
    for (int k = 0; k < 8; k++) begin
      bq.push_back({1'b0, 1'b1, k == 0, d[k]});
      if (k == gap_after) repeat (gap_len) bq.push_back({2'b00, 1'($urandom), 1'($urandom)});
    end
  endtask

  task automatic test_reset();
    step({1'b1, 1'b1, 1'b1, 1'b1});
    checks++;
    if (got() !== 14'h0) begin
      errors++; $display("FAIL reset: got %h need %h", got(), 14'h0);
    end
  endtask

  task automatic test_single_frame();
    int fv = 0;
    bq.delete();
    add_frame(8'h4D);
    foreach (bq[i]) begin
      step(bq[i]);
      fv += int'(frame_valid);
      checks++;
      if (got() !== expv()) begin errors++; $display("FAIL single[%0d]: got %h need %h", i, got(), expv()); end
    end
    checks++;
    if ({fv[1:0], y, locked, s} !== {2'd1, 8'h4D, 1'b1, 3'd0}) begin
      errors++; $display("FAIL single_final: fv=%0d y=%h locked=%b s=%0d need 1 4d 1 0", fv, y, locked, s);
    end
  endtask

  task automatic test_back_to_back();
    int fvc[$];
    logic [7:0] ys[$];
    bq.delete();
    add_frame(8'h4D);
    add_frame(8'hB2);
    foreach (bq[i]) begin
      step(bq[i]);
      if (frame_valid) begin fvc.push_back(cyc); ys.push_back(y); end
      checks++;
      if (got() !== expv()) begin errors++; $display("FAIL b2b[%0d]: got %h need %h", i, got(), expv()); end
    end
    checks++;
    if (fvc.size() != 2 || fvc[1] - fvc[0] != 8 || ys[0] !== 8'h4D || ys[1] !== 8'hB2) begin
      errors++; $display("FAIL b2b_pulses: count=%0d need 2 spaced 8 with y 4d,b2", fvc.size());
    end
  endtask

  task automatic test_gap();
    int fvc = -1, start;
    bq.delete();
    add_frame(8'hC5, 4, 3);
    start = cyc;
    foreach (bq[i]) begin
      step(bq[i]);
      if (frame_valid) fvc = cyc - start;
      checks++;
      if (got() !== expv()) begin errors++; $display("FAIL gap[%0d]: got %h need %h", i, got(), expv()); end
      if (i >= 5 && i <= 7) begin
        checks++;
        if (s !== 3'd5) begin errors++; $display("FAIL gap_hold: s=%0d need 5", s); end
      end
    end
    checks++;
    if (fvc != 11 || y !== 8'hC5) begin
      errors++; $display("FAIL gap_final: fv at %0d y=%h need 11 c5", fvc, y);
    end
  endtask

  task automatic test_realign();
    logic [7:0] y0;
    int se = 0;
    bq.delete();
    for (int k = 0; k < 5; k++) bq.push_back({1'b0, 1'b1, k == 0, 1'b1});
    add_frame(8'h96);
    y0 = y;
    foreach (bq[i]) begin
      step(bq[i]);
      se += int'(sync_err);
      checks++;
      if (got() !== expv()) begin errors++; $display("FAIL realign[%0d]: got %h need %h", i, got(), expv()); end
      if (i == 5) begin
        checks++;
        if ({sync_err, y} !== {1'b1, y0}) begin errors++; $display("FAIL realign_err: se=%b y=%h need 1 %h", sync_err, y, y0); end
      end
    end
    checks++;
    if (se != 1 || y !== 8'h96) begin errors++; $display("FAIL realign_final: errs=%0d y=%h need 1 96", se, y); end
  endtask

  task automatic test_loss();
    int se = 0;
    bq.delete();
    add_frame(8'h3C);
    repeat (6) bq.push_back({2'b01, 1'b0, 1'($urandom)});
    foreach (bq[i]) begin
      step(bq[i]);
      se += int'(sync_err);
      checks++;
      if (got() !== expv()) begin errors++; $display("FAIL loss[%0d]: got %h need %h", i, got(), expv()); end
    end
    checks++;
    if (se != 1 || locked !== 1'b0 || y !== 8'h3C) begin
      errors++; $display("FAIL loss_final: errs=%0d locked=%b y=%h need 1 0 3c", se, locked, y);
    end
  endtask

  task automatic test_mid_reset();
    bq.delete();
    add_frame(8'hE1);
    for (int k = 0; k < 3; k++) bq.push_back({1'b0, 1'b1, k == 0, 1'b1});
    bq.push_back(4'b1111);
    add_frame(8'h5A);
    foreach (bq[i]) begin
      step(bq[i]);
      checks++;
      if (got() !== expv()) begin errors++; $display("FAIL midrst[%0d]: got %h need %h", i, got(), expv()); end
      if (i == 11) begin
        checks++;
        if (got() !== 14'h0) begin errors++; $display("FAIL midrst_clear: got %h need 0", got()); end
      end
    end
    checks++;
    if (y !== 8'h5A) begin errors++; $display("FAIL midrst_final: y=%h need 5a", y); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [3:0] b;
      b = {$urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, 1'($urandom)};
      step(b);
      checks++;
      if (got() !== expv()) begin errors++; $display("FAIL random[%0d]: got %h need %h", i, got(), expv()); end
    end
  endtask

  initial begin
    {rst, din_valid, frame_start, din} = 4'b1000;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap();
    test_realign();
    test_loss();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
